// File: rtl/imm_gen_unit_pkg.sv
// Shared immediate-format encodings for the RV32I decode stage.
package imm_gen_unit_pkg;

    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_S     = 3'b001;
    localparam logic [2:0] IMM_B     = 3'b010;
    localparam logic [2:0] IMM_U     = 3'b011;
    localparam logic [2:0] IMM_J     = 3'b100;
    localparam logic [2:0] IMM_SHAMT = 3'b101;
    localparam logic [2:0] IMM_ZIMM  = 3'b110;

endpackage

// File: rtl/imm_gen_unit_extract.sv
// Combinational immediate extraction and extension for each RV32I format.
module imm_extract
    import imm_gen_unit_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [2:0]  immSel,
    output logic [31:0] imm
);

    logic signBit;
    assign signBit = instr[31];

    always_comb begin
        imm = 32'h0;
        case (immSel)
            IMM_I:     imm = {{20{signBit}}, instr[31:20]};
            IMM_S:     imm = {{20{signBit}}, instr[31:25], instr[11:7]};
            IMM_B:     imm = {{19{signBit}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:     imm = {instr[31:12], 12'h000};
            IMM_J:     imm = {{11{signBit}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_SHAMT: imm = {27'b0, instr[24:20]};
            IMM_ZIMM:  imm = {27'b0, instr[19:15]};
            // reserved and unknown selects yield zero so X never reaches the ALU
            default:   imm = 32'h0;
        endcase
    end

endmodule

// File: rtl/imm_gen_unit.sv
// Immediate generator: format mux followed by one register aligned to the decode/execute boundary.
module imm_gen_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [XLEN-1:0] Instr,
    input  logic [2:0]      ImmSel,
    output logic [XLEN-1:0] ExtImm,
    output logic            ExtImm_valid
);

    logic [31:0] immP0;

    imm_extract uExtract (
        .instr  (Instr),
        .immSel (ImmSel),
        .imm    (immP0)
    );

    // p0 -> p1: capture on enable, hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ExtImm       <= '0;
            ExtImm_valid <= 1'b0;
        end else begin
            ExtImm_valid <= en;
            if (en) begin
                ExtImm <= immP0;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_unit.sv
// Scoreboard bench for imm_gen_unit using known RV32I instruction encodings.
module tb_imm_gen_unit;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] Instr;
    logic [2:0]  ImmSel;
    logic [31:0] ExtImm;
    logic        ExtImm_valid;

    typedef struct {
        string       tag;
        logic [31:0] imm;
        logic        vld;
    } exp_t;

    exp_t        sb[$];
    int          total;
    int          bad;
    logic [31:0] lastImm;

    imm_gen_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .Instr        (Instr),
        .ImmSel       (ImmSel),
        .ExtImm       (ExtImm),
        .ExtImm_valid (ExtImm_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // drive on the falling edge and record what the next rising edge must produce
    task automatic drive(input string tag, input logic e, input logic [31:0] ins,
                         input logic [2:0] sel, input logic [31:0] expImm);
        exp_t item;
        @(negedge clk);
        en     = e;
        Instr  = ins;
        ImmSel = sel;
        if (e) lastImm = expImm;
        item.tag = tag;
        item.imm = lastImm;
        item.vld = e;
        sb.push_back(item);
    endtask

    task automatic observe();
        exp_t item;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checkVal("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            item = sb.pop_front();
            checkVal({item.tag, "_imm"}, ExtImm, item.imm);
            checkVal({item.tag, "_vld"}, {31'b0, ExtImm_valid}, {31'b0, item.vld});
        end
    endtask

    task automatic step(input string tag, input logic e, input logic [31:0] ins,
                        input logic [2:0] sel, input logic [31:0] expImm);
        drive(tag, e, ins, sel, expImm);
        observe();
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        lastImm = 32'h0;
        rst     = 1'b1;
        en      = 1'b0;
        Instr   = 32'h0;
        ImmSel  = 3'b000;
        #1;
        checkVal("reset_imm", ExtImm, 32'h0);
        checkVal("reset_vld", {31'b0, ExtImm_valid}, 32'h0);

        // release reset together with en=1; the capture lands on the following edge
        @(negedge clk);
        rst    = 1'b0;
        en     = 1'b1;
        Instr  = 32'h0000B7B7;
        ImmSel = 3'b011;
        lastImm = 32'h0000B000;
        begin
            exp_t item;
            item.tag = "rst_release_u";
            item.imm = 32'h0000B000;
            item.vld = 1'b1;
            sb.push_back(item);
        end
        observe();

        step("i_addi",   1'b1, 32'hFD010113, 3'b000, 32'hFFFFFFD0);
        step("j_jal",    1'b1, 32'hF99FF0EF, 3'b100, 32'hFFFFFF98);
        step("u_lui",    1'b1, 32'h0000B7B7, 3'b011, 32'h0000B000);
        step("s_sw",     1'b1, 32'h00A12423, 3'b001, 32'h00000008);
        step("b_beq",    1'b1, 32'hFE000CE3, 3'b010, 32'hFFFFFFF8);
        step("shamt",    1'b1, 32'h40F05793, 3'b101, 32'h0000000F);
        step("zimm",     1'b1, 32'h40F05793, 3'b110, 32'h00000000);
        step("reserved", 1'b1, 32'hFFFFFFFF, 3'b111, 32'h00000000);
        step("i_allone", 1'b1, 32'hFFFFFFFF, 3'b000, 32'hFFFFFFFF);
        step("j_allone", 1'b1, 32'hFFFFFFFF, 3'b100, 32'hFFFFFFFE);
        step("s_pos",    1'b1, 32'h7E000F80, 3'b001, 32'h000007FF);
        step("zimm_max", 1'b1, 32'h000F8000, 3'b110, 32'h0000001F);

        // hold: value stays while en is low even as inputs change
        step("hold_cap", 1'b1, 32'hFD010113, 3'b000, 32'hFFFFFFD0);
        step("hold_1",   1'b0, 32'h0000B7B7, 3'b011, 32'h0);
        step("hold_2",   1'b0, 32'hF99FF0EF, 3'b100, 32'h0);

        // asynchronous reset mid-cycle while holding a nonzero value
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkVal("async_rst_imm", ExtImm, 32'h0);
        checkVal("async_rst_vld", {31'b0, ExtImm_valid}, 32'h0);
        en     = 1'b1;
        Instr  = 32'hFD010113;
        ImmSel = 3'b000;
        @(posedge clk);
        #1;
        checkVal("rst_held_imm", ExtImm, 32'h0);
        checkVal("rst_held_vld", {31'b0, ExtImm_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        lastImm = 32'h0;

        step("post_rst", 1'b1, 32'hFE000CE3, 3'b010, 32'hFFFFFFF8);

        checkVal("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
